// File: rtl/myrsp_depacketizer.sv
// myRSP receive depacketizer: strips the 6-byte scene/row/col header, streams payload
// bytes with packet metadata, and keeps saturating error/sequence statistics.
module myrsp_depacketizer #(
  parameter int PIX_DLEN    = 8,
  parameter int MAX_PAYLOAD = 1400,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [PIX_DLEN-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [15:0]         m_scene,
  output logic [15:0]         m_row,
  output logic [15:0]         m_col,
  output logic [CNT_W-1:0]    stat_short,
  output logic [CNT_W-1:0]    stat_long,
  output logic [CNT_W-1:0]    stat_empty,
  output logic [CNT_W-1:0]    stat_row_gap
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

  localparam logic [15:0] PAY_LAST = 16'(MAX_PAYLOAD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [2:0]  hdr_idx;
  logic [39:0] hdr_sr;
  logic [15:0] pay_cnt;
  logic        rdy_q;
  logic        first_pkt;
  logic        new_scene;
  logic        first_byte;
  logic        meta_pend;
  logic [15:0] last_scene;
  logic [15:0] last_row;
  logic [15:0] pend_scene;
  logic [15:0] pend_row;
  logic [15:0] pend_col;

  logic        out_free;
  logic        in_acc;
  logic        pay_last;
  logic [15:0] hdr_scene;
  logic [15:0] hdr_row;
  logic [15:0] hdr_col;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // Header bytes shift in from the top, so after five bytes byte 0 sits at [7:0];
  // byte 5 is taken straight from the input on the completing edge.
  always_comb begin
    out_free      = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = rdy_q && ((state != S_PAY) || out_free);
    in_acc        = s_axis_tvalid && s_axis_tready;
    pay_last      = (pay_cnt == PAY_LAST);
    hdr_scene     = hdr_sr[15:0];
    hdr_row       = hdr_sr[31:16];
    hdr_col       = {s_axis_tdata, hdr_sr[39:32]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_HDR;
      hdr_idx       <= 3'd0;
      pay_cnt       <= 16'd0;
      rdy_q         <= 1'b0;
      first_pkt     <= 1'b1;
      new_scene     <= 1'b0;
      first_byte    <= 1'b0;
      meta_pend     <= 1'b0;
      last_scene    <= 16'd0;
      last_row      <= 16'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_scene       <= 16'd0;
      m_row         <= 16'd0;
      m_col         <= 16'd0;
      stat_short    <= '0;
      stat_long     <= '0;
      stat_empty    <= '0;
      stat_row_gap  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (out_free) m_axis_tvalid <= 1'b0;
      // Metadata of a header that completed behind a stalled beat lands once it drains.
      if (meta_pend && out_free) begin
        m_scene   <= pend_scene;
        m_row     <= pend_row;
        m_col     <= pend_col;
        meta_pend <= 1'b0;
      end

      case (state)
        S_HDR: begin
          if (in_acc) begin
            hdr_sr <= {s_axis_tdata, hdr_sr[39:8]};
            if (s_axis_tlast) begin
              hdr_idx <= 3'd0;
              if (hdr_idx == 3'd5) stat_empty <= sat_inc(stat_empty);
              else                 stat_short <= sat_inc(stat_short);
            end else if (hdr_idx == 3'd5) begin
              hdr_idx    <= 3'd0;
              state      <= S_PAY;
              pay_cnt    <= 16'd0;
              first_byte <= 1'b1;
              if (!first_pkt && (hdr_scene == last_scene) && (hdr_row != last_row) &&
                  (hdr_row != 16'(last_row + 16'd1)))
                stat_row_gap <= sat_inc(stat_row_gap);
              last_scene <= hdr_scene;
              last_row   <= hdr_row;
              new_scene  <= first_pkt || (hdr_scene != last_scene);
              first_pkt  <= 1'b0;
              if (out_free) begin
                m_scene <= hdr_scene;
                m_row   <= hdr_row;
                m_col   <= hdr_col;
              end else begin
                pend_scene <= hdr_scene;
                pend_row   <= hdr_row;
                pend_col   <= hdr_col;
                meta_pend  <= 1'b1;
              end
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
        end

        S_PAY: begin
          // Acceptance here implies the output register is free this cycle.
          if (in_acc) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast || pay_last;
            m_axis_tuser  <= new_scene && first_byte;
            first_byte    <= 1'b0;
            pay_cnt       <= pay_cnt + 16'd1;
            if (s_axis_tlast) begin
              state   <= S_HDR;
              hdr_idx <= 3'd0;
              pay_cnt <= 16'd0;
            end else if (pay_last) begin
              stat_long <= sat_inc(stat_long);
              state     <= S_DROP;
            end
          end
        end

        S_DROP: begin
          if (in_acc && s_axis_tlast) begin
            state   <= S_HDR;
            hdr_idx <= 3'd0;
            pay_cnt <= 16'd0;
          end
        end

        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_myrsp_depacketizer.sv
// Directed self-checking bench for myrsp_depacketizer (MAX_PAYLOAD reduced to 4).
module tb_myrsp_depacketizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] m_scene, m_row, m_col;
  logic [15:0] stat_short, stat_long, stat_empty, stat_row_gap;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  myrsp_depacketizer #(.PIX_DLEN(8), .MAX_PAYLOAD(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .m_scene(m_scene), .m_row(m_row), .m_col(m_col),
    .stat_short(stat_short), .stat_long(stat_long),
    .stat_empty(stat_empty), .stat_row_gap(stat_row_gap)
  );

  // Beats are recorded mid-cycle; a beat seen valid&ready here is taken on the next edge.
  always @(negedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready)
      q.push_back('{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser});

  task automatic put(input logic [7:0] d, input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL put_timeout: s_axis_tready stayed %0b, required 1", s_axis_tready);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] sc, input logic [15:0] rw, input logic [15:0] cl);
    put(sc[7:0], 1'b0); put(sc[15:8], 1'b0);
    put(rw[7:0], 1'b0); put(rw[15:8], 1'b0);
    put(cl[7:0], 1'b0); put(cl[15:8], 1'b0);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      failures++; $display("FAIL reset_mout: got v%0b l%0b u%0b d%02h want all 0",
                           m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    checks++;
    if ({m_scene, m_row, m_col, stat_short, stat_long, stat_empty, stat_row_gap} !== 112'd0) begin
      failures++; $display("FAIL reset_meta_stats: got %h want 0",
                           {m_scene, m_row, m_col, stat_short, stat_long, stat_empty, stat_row_gap});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_release_tready: got %0b want 1", s_axis_tready); end
  endtask

  task automatic test_basic();
    q.delete();
    send_hdr(16'd1, 16'd5, 16'd0);
    put(8'hAA, 1'b0); put(8'hBB, 1'b0); put(8'hCC, 1'b1);
    drain();
    checks++;
    if (q.size() != 3) begin failures++; $display("FAIL basic_count: got %0d want 3", q.size()); end
    else begin
      checks++;
      if (q[0] !== '{data: 8'hAA, last: 1'b0, user: 1'b1} || q[1] !== '{data: 8'hBB, last: 1'b0, user: 1'b0} ||
          q[2] !== '{data: 8'hCC, last: 1'b1, user: 1'b0}) begin
        failures++; $display("FAIL basic_beats: got %h %h %h want aa1 bb0 cc2 (data,last,user)",
                             q[0], q[1], q[2]);
      end
    end
    checks++;
    if (m_scene !== 16'd1 || m_row !== 16'd5 || m_col !== 16'd0) begin
      failures++; $display("FAIL basic_meta: got %0d/%0d/%0d want 1/5/0", m_scene, m_row, m_col);
    end
  endtask

  task automatic test_row_gap();
    logic [15:0] rows [4] = '{16'd5, 16'd5, 16'd6, 16'd9};
    q.delete();
    foreach (rows[i]) begin
      send_hdr(16'd1, rows[i], 16'd0);
      put(8'h10 + 8'(i), 1'b1);
    end
    drain();
    checks++;
    if (stat_row_gap !== 16'd1) begin failures++; $display("FAIL rowgap_count: got %0d want 1", stat_row_gap); end
    checks++;
    if (q.size() != 4 || q[0].user !== 1'b0 || q[3].user !== 1'b0 || q[3].data !== 8'h13) begin
      failures++; $display("FAIL rowgap_beats: got n=%0d want 4 beats without tuser", q.size());
    end
    q.delete();
    send_hdr(16'd2, 16'd0, 16'd3);
    put(8'h20, 1'b1);
    drain();
    checks++;
    if (q.size() != 1 || q[0] !== '{data: 8'h20, last: 1'b1, user: 1'b1}) begin
      failures++; $display("FAIL newscene_tuser: got n=%0d beat=%h want 1 beat 203", q.size(), q.size() ? q[0] : 10'h0);
    end
    checks++;
    if (stat_row_gap !== 16'd1 || m_scene !== 16'd2 || m_col !== 16'd3) begin
      failures++; $display("FAIL newscene_meta: got gap=%0d scene=%0d col=%0d want 1/2/3", stat_row_gap, m_scene, m_col);
    end
  endtask

  task automatic test_short_empty();
    q.delete();
    put(8'h02, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b1);
    drain();
    checks++;
    if (stat_short !== 16'd1 || q.size() != 0) begin
      failures++; $display("FAIL short_pkt: got short=%0d beats=%0d want 1/0", stat_short, q.size());
    end
    send_hdr(16'd2, 16'd1, 16'h0102);
    put(8'h11, 1'b0); put(8'h22, 1'b1);
    drain();
    checks++;
    if (q.size() != 2 || q[0] !== '{data: 8'h11, last: 1'b0, user: 1'b0} || q[1] !== '{data: 8'h22, last: 1'b1, user: 1'b0}) begin
      failures++; $display("FAIL short_recover_beats: got n=%0d want 11,22(last)", q.size());
    end
    checks++;
    if (m_scene !== 16'd2 || m_row !== 16'd1 || m_col !== 16'h0102 || stat_row_gap !== 16'd1) begin
      failures++; $display("FAIL short_recover_meta: got %0d/%0d/%h gap=%0d want 2/1/0102 gap=1",
                           m_scene, m_row, m_col, stat_row_gap);
    end
    q.delete();
    put(8'h09, 1'b0); put(8'h00, 1'b0); put(8'h09, 1'b0);
    put(8'h00, 1'b0); put(8'h09, 1'b0); put(8'h00, 1'b1);
    drain();
    checks++;
    if (stat_empty !== 16'd1 || q.size() != 0 || m_scene !== 16'd2 || m_row !== 16'd1) begin
      failures++; $display("FAIL empty_pkt: got empty=%0d beats=%0d scene=%0d row=%0d want 1/0/2/1",
                           stat_empty, q.size(), m_scene, m_row);
    end
  endtask

  task automatic test_long();
    q.delete();
    send_hdr(16'd2, 16'd2, 16'd0);
    for (int i = 0; i < 7; i++) put(8'h30 + 8'(i), (i == 6));
    drain();
    checks++;
    if (q.size() != 4) begin failures++; $display("FAIL long_count: got %0d want 4", q.size()); end
    else begin
      checks++;
      if (q[0].last !== 1'b0 || q[2].last !== 1'b0 || q[3] !== '{data: 8'h33, last: 1'b1, user: 1'b0}) begin
        failures++; $display("FAIL long_tlast: got last beat %h want 33 with last", q[3]);
      end
    end
    checks++;
    if (stat_long !== 16'd1) begin failures++; $display("FAIL long_stat: got %0d want 1", stat_long); end
    q.delete();
    send_hdr(16'd2, 16'd3, 16'd7);
    put(8'h3F, 1'b1);
    drain();
    checks++;
    if (q.size() != 1 || q[0] !== '{data: 8'h3F, last: 1'b1, user: 1'b0} || m_row !== 16'd3 || m_col !== 16'd7) begin
      failures++; $display("FAIL long_recover: got n=%0d row=%0d col=%0d want 1 beat 3f row 3 col 7",
                           q.size(), m_row, m_col);
    end
  endtask

  task automatic test_backpressure();
    q.delete();
    m_axis_tready = 1'b1;
    fork
      begin
        send_hdr(16'd2, 16'd4, 16'd0);
        put(8'hAA, 1'b0); put(8'hBB, 1'b0); put(8'hCC, 1'b1);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk); n++;
        end while (!m_axis_tvalid && n < 200);
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          checks++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hBB || s_axis_tready !== 1'b0) begin
            failures++; $display("FAIL stall_hold: got v%0b d%02h in_rdy%0b want v1 dBB in_rdy0",
                                 m_axis_tvalid, m_axis_tdata, s_axis_tready);
          end
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();
    checks++;
    if (q.size() != 3 || q[0].data !== 8'hAA || q[1].data !== 8'hBB || q[2] !== '{data: 8'hCC, last: 1'b1, user: 1'b0}) begin
      failures++; $display("FAIL stall_order: got n=%0d want AA,BB,CC", q.size());
    end
  endtask

  task automatic test_reset_mid();
    send_hdr(16'd3, 16'd0, 16'd0);
    put(8'h50, 1'b0); put(8'h51, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_scene, m_row, m_col,
         stat_short, stat_long, stat_empty, stat_row_gap, s_axis_tready} !== 124'd0) begin
      failures++; $display("FAIL midreset_clear: got scene=%0d short=%0d long=%0d empty=%0d gap=%0d v%0b want all 0",
                           m_scene, stat_short, stat_long, stat_empty, stat_row_gap, m_axis_tvalid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    send_hdr(16'd7, 16'd2, 16'd1);
    put(8'h44, 1'b1);
    drain();
    checks++;
    if (q.size() != 1 || q[0] !== '{data: 8'h44, last: 1'b1, user: 1'b1} || m_scene !== 16'd7 || m_row !== 16'd2) begin
      failures++; $display("FAIL midreset_recover: got n=%0d scene=%0d row=%0d want 1 beat 44 tuser scene 7 row 2",
                           q.size(), m_scene, m_row);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_gap();
    test_short_empty();
    test_long();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/myrsp_depacketizer.md
Name: myrsp_depacketizer

Overview:
- Receive end of the myRSP streaming protocol.
- Consumes the myRSP byte stream after UDP decapsulation (one AXI-Stream packet per UDP datagram) and strips the 6-byte header (scene, row, col).
- Emits raw pixel bytes with per-packet metadata and frame/packet delimiters for the frame-buffer writer.
- Also maintains error and sequence statistics for host readout.

Parameters:
- PIX_DLEN, 8, output pixel width; must be 8 (byte-serial payload).
- MAX_PAYLOAD, 1400, maximum accepted payload bytes per packet, header excluded.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  8  myRSP byte stream
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last byte of datagram
- m_axis_tdata  out  PIX_DLEN  pixel byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last payload byte of packet
- m_axis_tuser  out  1  first payload byte of a new scene
- m_scene  out  16  scene index of current packet
- m_row  out  16  row index of current packet
- m_col  out  16  col index of current packet
- stat_short  out  CNT_W  packets ended inside header
- stat_long  out  CNT_W  packets truncated at MAX_PAYLOAD
- stat_empty  out  CNT_W  header-only packets
- stat_row_gap  out  CNT_W  row discontinuities within a scene

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=S_HDR, hdr_idx=0, all m_* outputs and stat_* = 0, s_axis_tready=0.
  - first_pkt=1, last_scene=0, last_row=0.
  - Reset mid-packet abandons the packet; the next byte after reset is treated as header byte 0.
- Header format: bytes 0..5 = scene[7:0], scene[15:8], row[7:0], row[15:8], col[7:0], col[15:8] (little-endian per field).
- S_HDR:
  - s_axis_tready=1 (registered, asserted from the cycle after reset release).
  - Each accepted byte is stored at hdr_idx, then hdr_idx increments.
  - tlast with hdr_idx<5: stat_short++, hdr_idx=0, stay in S_HDR; no output, metadata unchanged.
  - tlast with hdr_idx==5: stat_empty++, hdr_idx=0, stay in S_HDR; no output, metadata unchanged.
  - Byte 5 accepted without tlast: go to S_PAY. m_scene/m_row/m_col update on the next edge.
  - Same edge as the S_PAY transition, sequence check:
    - If !first_pkt, scene==last_scene, row!=last_row and row!=last_row+1 (mod 2^16): stat_row_gap++.
    - Then last_scene=scene, last_row=row.
    - new_scene = first_pkt || scene!=last_scene (old value); then first_pkt=0.
- S_PAY:
  - Single output register; s_axis_tready = m_axis_tready || !m_axis_tvalid (combinational).
  - Each accepted byte is loaded into the output register with 1-cycle latency.
  - tuser=1 only on the first payload byte of a packet with new_scene=1.
  - tlast = s_axis_tlast || (pay_cnt==MAX_PAYLOAD-1). pay_cnt counts accepted payload bytes from 0.
  - Accepted byte with s_axis_tlast: go to S_HDR, hdr_idx=0, pay_cnt=0.
  - Accepted byte with pay_cnt==MAX_PAYLOAD-1 and no s_axis_tlast: stat_long++, go to S_DROP.
- S_DROP:
  - s_axis_tready=1; bytes are discarded.
  - tlast returns to S_HDR with hdr_idx=0.
- Output hold: while m_axis_tvalid=1 and m_axis_tready=0, tdata/tlast/tuser stay stable.
- Metadata: m_scene/m_row/m_col update only on header completion, never while an unaccepted beat of the previous packet is pending. Header byte acceptance in S_HDR is independent of the output, so the header is collected while the last beat waits. The metadata update is deferred until that beat is accepted.
- Statistics counters: saturate at all-ones and never wrap.
- No backpressure is applied to input in S_HDR or S_DROP, so the upstream UDP stack never stalls on malformed traffic.

Test Plan:
1. Packet: header 01 00 05 00 00 00, payload AA BB CC, tlast on CC, m_axis_tready=1 -> output AA,BB,CC; tuser=1 on AA only; tlast on CC; m_scene=1, m_row=5, m_col=0.
2. Same-scene packets with rows 5, 5, 6, 9 -> stat_row_gap=1. A following packet with scene 2 and row 0 -> tuser=1 on its first byte, no gap counted.
3. 4-byte datagram with tlast on byte 3 -> stat_short=1, no output beats; the next well-formed packet decodes correctly. A 6-byte header-only datagram -> stat_empty=1.
4. MAX_PAYLOAD=4, payload of 7 bytes -> 4 output bytes, tlast on the 4th, stat_long=1; the next packet header parses correctly.
5. m_axis_tready toggling 1,0,0,1 through a 3-byte payload -> no byte lost or duplicated; outputs held stable while stalled; s_axis_tready low only when the output register is full and not ready.
6. rst_n asserted after 2 payload bytes -> all outputs and stats return to 0; the next header parses; tuser=1 on the next first payload byte.
